// File: rtl/logic_unit_pkg.sv
// Shared opcode encoding and default width for the registered bitwise logic unit.
// Optional parity output is controlled by the LOGIC_UNIT_PARITY_EN macro.
package logic_unit_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int OP_BITS       = 3;

    typedef enum logic [OP_BITS-1:0] {
        OP_OR   = 3'b000,
        OP_NOT  = 3'b001,
        OP_OR1  = 3'b010,
        OP_AND  = 3'b011,
        OP_XOR  = 3'b100,
        OP_NOR  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } op_e;

endpackage : logic_unit_pkg

// File: rtl/logic_unit_if.sv
// Operand/opcode request and registered result bundle for logic_unit.
// The parity signal exists only when LOGIC_UNIT_PARITY_EN is defined.
interface logic_unit_if
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic               in_valid;
    logic [OP_BITS-1:0] op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic [WIDTH-1:0]   result;
    logic               op_err;
    logic               zero;
`ifdef LOGIC_UNIT_PARITY_EN
    logic               parity;

    modport master (
        output in_valid, op, a, b,
        input  out_valid, result, op_err, zero, parity
    );

    modport slave (
        input  in_valid, op, a, b,
        output out_valid, result, op_err, zero, parity
    );
`else
    modport master (
        output in_valid, op, a, b,
        input  out_valid, result, op_err, zero
    );

    modport slave (
        input  in_valid, op, a, b,
        output out_valid, result, op_err, zero
    );
`endif

endinterface : logic_unit_if

// File: rtl/logic_unit_core.sv
// Combinational opcode decode and bitwise evaluation; reserved opcodes yield
// a zero result with the error flag set.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [OP_BITS-1:0] op_i,
    output logic [WIDTH-1:0]   res_o,
    output logic               err_o
);

    // Opcode decode and bitwise evaluation
    always_comb begin
        res_o = {WIDTH{1'b0}};
        err_o = 1'b0;
        case (op_i)
            OP_OR:   res_o = a_i | b_i;
            OP_NOT:  res_o = ~a_i;
            OP_OR1:  res_o = {{(WIDTH-1){1'b0}}, a_i[0] | b_i[0]};
            OP_AND:  res_o = a_i & b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            OP_NOR:  res_o = ~(a_i | b_i);
            default: begin
                res_o = {WIDTH{1'b0}};
                err_o = 1'b1;
            end
        endcase
    end

endmodule : logic_unit_core

// File: rtl/logic_unit.sv
// Registered bitwise logic unit: one-cycle latency, full throughput, flags held
// while idle. Defining LOGIC_UNIT_PARITY_EN adds a registered parity output.
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    logic_unit_if.slave  bus
);

    logic [WIDTH-1:0] core_res_s;
    logic             core_err_s;

    logic             valid_q,  valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q,    err_d;
    logic             zero_q,   zero_d;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .a_i   (bus.a),
        .b_i   (bus.b),
        .op_i  (bus.op),
        .res_o (core_res_s),
        .err_o (core_err_s)
    );

    // Capture on in_valid; otherwise drop the strobe and hold the last result
    always_comb begin
        valid_d  = bus.in_valid;
        result_d = result_q;
        err_d    = err_q;
        zero_d   = zero_q;
        if (bus.in_valid) begin
            result_d = core_res_s;
            err_d    = core_err_s;
            zero_d   = (core_res_s == {WIDTH{1'b0}});
        end else begin
            result_d = result_q;
            err_d    = err_q;
            zero_d   = zero_q;
        end
    end

    // Output pipeline register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            err_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            err_q    <= err_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.result    = result_q;
    assign bus.op_err    = err_q;
    assign bus.zero      = zero_q;

`ifdef LOGIC_UNIT_PARITY_EN
    function automatic logic even_parity(input logic [WIDTH-1:0] value);
        return ^value;
    endfunction

    logic parity_q, parity_d;

    // Parity follows the same capture/hold rule as zero
    always_comb begin
        parity_d = parity_q;
        if (bus.in_valid) begin
            parity_d = even_parity(core_res_s);
        end else begin
            parity_d = parity_q;
        end
    end

    // Parity register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign bus.parity = parity_q;
`endif

endmodule : logic_unit

// File: tb/tb_logic_unit.sv
// Self-checking bench for logic_unit: directed vector table followed by random
// stimulus against a bit-level reference model.
module tb_logic_unit;
    import logic_unit_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic_unit_if #(.WIDTH(W)) bus ();

    logic_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference state
    logic         m_valid;
    logic [W-1:0] m_result;
    logic         m_err;
    logic         m_zero;

    typedef struct {
        logic         r;
        logic         iv;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ev;
        logic [W-1:0] er;
        logic         ee;
        logic         ez;
    } vec_t;

    localparam int NVEC = 20;
    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bit-by-bit truth evaluation of each opcode
    function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, output logic err);
        logic [W-1:0] r;
        int ai, bi, v;
        r   = '0;
        err = 1'b0;
        for (int i = 0; i < W; i++) begin
            ai = int'(a[i]);
            bi = int'(b[i]);
            case (int'(op))
                0: v = (ai + bi > 0) ? 1 : 0;
                1: v = 1 - ai;
                2: v = (i == 0) ? ((ai + bi > 0) ? 1 : 0) : 0;
                3: v = ai * bi;
                4: v = (ai + bi) % 2;
                5: v = (ai + bi > 0) ? 0 : 1;
                default: begin v = 0; err = 1'b1; end
            endcase
            r[i] = (v != 0);
        end
        return r;
    endfunction

    task automatic apply(input logic r, input logic iv, input logic [2:0] o,
                         input logic [W-1:0] va, input logic [W-1:0] vb);
        logic e;
        @(negedge clk);
        rst          = r;
        bus.in_valid = iv;
        bus.op       = o;
        bus.a        = va;
        bus.b        = vb;
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 1'b0; m_result = '0; m_err = 1'b0; m_zero = 1'b0;
        end else if (iv) begin
            m_result = ref_op(o, va, vb, e);
            m_err    = e;
            m_valid  = 1'b1;
            m_zero   = (m_result == '0);
        end else begin
            m_valid = 1'b0;
        end
        // Scramble operands between edges; they must not affect held outputs
        bus.a  = W'($urandom);
        bus.b  = W'($urandom);
        bus.op = 3'($urandom);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"},  32'(bus.out_valid), 32'(m_valid));
        check({tag, ".result"}, 32'(bus.result),    32'(m_result));
        check({tag, ".op_err"}, 32'(bus.op_err),    32'(m_err));
        check({tag, ".zero"},   32'(bus.zero),      32'(m_zero));
`ifdef LOGIC_UNIT_PARITY_EN
        check({tag, ".parity"}, 32'(bus.parity),    32'(^m_result));
`endif
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.op       = 3'b000;
        bus.a        = '0;
        bus.b        = '0;

        //          r     iv    op      a         b         ev    er        ee    ez
        tbl[0]  = '{1'b1, 1'b1, 3'b000, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 3'b000, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 3'b000, 16'h00F0, 16'h0F00, 1'b1, 16'h0FF0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 3'b001, 16'h00F0, 16'h1234, 1'b1, 16'hFF0F, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 3'b010, 16'h0000, 16'hFFFE, 1'b1, 16'h0000, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 3'b010, 16'h0001, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 3'b011, 16'hAAAA, 16'hFFFF, 1'b1, 16'hAAAA, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 3'b100, 16'hAAAA, 16'hFFFF, 1'b1, 16'h5555, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 3'b101, 16'hAAAA, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 3'b110, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 3'b111, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 3'b000, 16'h00F0, 16'h0F00, 1'b1, 16'h0FF0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 3'b001, 16'hFFFF, 16'h0000, 1'b0, 16'h0FF0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 3'b110, 16'h0000, 16'h0000, 1'b0, 16'h0FF0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 3'b000, 16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 3'b000, 16'h0007, 16'h0000, 1'b1, 16'h0007, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 3'b101, 16'h0000, 16'h0000, 1'b0, 16'h0007, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 3'b110, 16'hBEEF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 3'b000, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[19] = '{1'b0, 1'b1, 3'b001, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1};

        for (int i = 0; i < NVEC; i++) begin
            apply(tbl[i].r, tbl[i].iv, tbl[i].op, tbl[i].a, tbl[i].b);
            check($sformatf("vec%0d.valid", i),  32'(bus.out_valid), 32'(tbl[i].ev));
            check($sformatf("vec%0d.result", i), 32'(bus.result),    32'(tbl[i].er));
            check($sformatf("vec%0d.op_err", i), 32'(bus.op_err),    32'(tbl[i].ee));
            check($sformatf("vec%0d.zero", i),   32'(bus.zero),      32'(tbl[i].ez));
`ifdef LOGIC_UNIT_PARITY_EN
            check($sformatf("vec%0d.parity", i), 32'(bus.parity),    32'(^tbl[i].er));
`endif
        end

        // Mid-stream reset drops the in-flight op, next valid op is normal
        apply(1'b0, 1'b1, 3'b011, 16'hF0F0, 16'hFF00);
        check_model("seq.pre_rst");
        apply(1'b1, 1'b1, 3'b000, 16'hFFFF, 16'hFFFF);
        check_model("seq.rst");
        apply(1'b0, 1'b1, 3'b100, 16'h0F0F, 16'h00FF);
        check("seq.post_rst.result", 32'(bus.result), 32'h0000_0FF0);
        check_model("seq.post_rst");

        for (int i = 0; i < 300; i++) begin
            apply(($urandom_range(15) == 0), ($urandom_range(3) != 0), 3'($urandom_range(7)),
                  W'($urandom), ($urandom_range(7) == 0) ? ~W'(0) : W'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_logic_unit
